// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets inside the 16-byte window, STATUS bit positions and the
// transmitter state encoding.
package mmio_uart_pkg;

   // Word offsets within the register window (bus_addr[3:2])
   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_BAUDDIV = 2'd2;

   // STATUS register bit positions
   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_COUNT_LSB = 8;
   localparam int ST_COUNT_W   = 5;

   // Serial frame phases: start bit, eight data bits, stop bit
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory bus as seen by a memory-mapped responder. The core side
// drives strobes, address and store data; the responder returns
// combinational read data and a hit flag used by the SoC read mux.
interface mmio_uart_tx_if;

   logic        bus_r;
   logic [3:0]  bus_w;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_hit;

   modport master (
      output bus_r, bus_w, bus_addr, bus_wdata,
      input  bus_rdata, bus_hit
   );

   modport slave (
      input  bus_r, bus_w, bus_addr, bus_wdata,
      output bus_rdata, bus_hit
   );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with a combinational head output. A push while full is
// still accepted when a pop happens in the same cycle, because the popped
// slot frees space for it at the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   // Storage array needs no reset; only written entries are ever read
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter. The core pushes bytes through TXDATA,
// they wait in a small FIFO and leave on uart_txd as 8N1 frames whose bit
// time is BAUDDIV clocks. Reads are combinational so single-cycle loads work.
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE       = 32'h8000_0000,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic            clk,
   input  logic            rst_n,
   mmio_uart_tx_if.slave   bus,
   output logic            uart_txd
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          hit;
   logic          wr_en;
   logic [1:0]    offset;
   logic [31:0]   status;
   logic [31:0]   rdata;
   logic [15:0]   bauddiv;
   logic [15:0]   baud_next;
   logic          overflow;

   logic          fifo_push;
   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   tx_state_t     state;
   logic [7:0]    shift;
   logic [15:0]   div_lat;
   logic [15:0]   cnt;
   logic [2:0]    bit_cnt;

   logic          unused_bits;

   assign offset      = bus.bus_addr[3:2];
   assign hit         = (bus.bus_addr[31:4] == BASE[31:4]) && (bus.bus_r || (bus.bus_w != 4'b0000));
   assign wr_en       = hit && (bus.bus_w != 4'b0000);
   assign bus.bus_hit = hit;
   assign bus.bus_rdata = rdata;
   assign unused_bits = ^{bus.bus_wdata[31:16], bus.bus_addr[1:0]};

   assign fifo_push = wr_en && (offset == OFF_TXDATA) && bus.bus_w[0];
   assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && (cnt == 16'd0)));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (bus.bus_wdata[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Assemble STATUS and pick the read data for the addressed register
   always_comb begin
      status = '0;
      status[ST_BUSY]     = (state != IDLE);
      status[ST_FULL]     = fifo_full;
      status[ST_EMPTY]    = fifo_empty;
      status[ST_OVERFLOW] = overflow;
      status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
      rdata = '0;
      if (hit) begin
         case (offset)
            OFF_STATUS:  rdata = status;
            OFF_BAUDDIV: rdata = {16'h0000, bauddiv};
            default:     rdata = '0;
         endcase
      end
   end

   // Merge enabled byte lanes into BAUDDIV; a zero divisor would stall the line
   always_comb begin
      baud_next = bauddiv;
      if (bus.bus_w[0]) begin
         baud_next[7:0] = bus.bus_wdata[7:0];
      end
      if (bus.bus_w[1]) begin
         baud_next[15:8] = bus.bus_wdata[15:8];
      end
      if (baud_next == 16'd0) begin
         baud_next = 16'd1;
      end
   end

   // BAUDDIV register; the running frame keeps its own latched copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bauddiv <= DIV_RESET;
      end else if (wr_en && (offset == OFF_BAUDDIV)) begin
         bauddiv <= baud_next;
      end
   end

   // Sticky overflow: set when a byte is dropped, cleared by writing 1 to bit3
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (fifo_push && fifo_full && !fifo_pop) begin
         overflow <= 1'b1;
      end else if (wr_en && (offset == OFF_STATUS) && bus.bus_w[0] && bus.bus_wdata[ST_OVERFLOW]) begin
         overflow <= 1'b0;
      end
   end

   // Frame serializer; STOP chains straight into START when more data waits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         uart_txd <= 1'b1;
         shift    <= '0;
         div_lat  <= DIV_RESET;
         cnt      <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  shift    <= fifo_dout;
                  div_lat  <= bauddiv;
                  cnt      <= bauddiv - 16'd1;
                  bit_cnt  <= '0;
                  uart_txd <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (cnt == 16'd0) begin
                  uart_txd <= shift[0];
                  cnt      <= div_lat - 16'd1;
                  state    <= DATA;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (cnt == 16'd0) begin
                  cnt <= div_lat - 16'd1;
                  if (bit_cnt == 3'd7) begin
                     uart_txd <= 1'b1;
                     state    <= STOP;
                  end else begin
                     shift    <= {1'b0, shift[7:1]};
                     uart_txd <= shift[1];
                     bit_cnt  <= bit_cnt + 3'd1;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (cnt == 16'd0) begin
                  if (!fifo_empty) begin
                     shift    <= fifo_dout;
                     div_lat  <= bauddiv;
                     cnt      <= bauddiv - 16'd1;
                     bit_cnt  <= '0;
                     uart_txd <= 1'b0;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state    <= IDLE;
               uart_txd <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx. A behavioural model keeps the FIFO as a queue and
// describes the line as "frame started N clocks ago with divisor D", from
// which the expected txd level follows by division.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE    = 32'h8000_0000;
   localparam logic [31:0] A_TX    = BASE;
   localparam logic [31:0] A_ST    = BASE + 32'd4;
   localparam logic [31:0] A_BD    = BASE + 32'd8;
   localparam logic [31:0] A_UNMAP = BASE + 32'd12;
   localparam logic [31:0] A_OUT   = BASE + 32'd16;
   localparam int          DEPTH   = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic txd;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [7:0]  q[$];
   logic        m_ovf;
   logic [15:0] m_baud;
   bit          m_busy;
   int          m_elapsed;
   int          m_div;
   logic [7:0]  m_byte;

   mmio_uart_tx_if bif ();

   mmio_uart_tx #(
      .BASE       (BASE),
      .FIFO_DEPTH (DEPTH),
      .DIV_RESET  (16'd434)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bif.slave),
      .uart_txd (txd)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   function automatic void model_reset();
      q.delete();
      m_ovf     = 1'b0;
      m_baud    = 16'd434;
      m_busy    = 1'b0;
      m_elapsed = 0;
      m_div     = 1;
      m_byte    = 8'h00;
   endfunction

   function automatic logic exp_txd();
      int idx;
      if (!m_busy) return 1'b1;
      idx = m_elapsed / m_div;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_byte[idx-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = '0;
      s[0] = m_busy;
      s[1] = (q.size() == DEPTH);
      s[2] = (q.size() == 0);
      s[3] = m_ovf;
      s[12:8] = 5'(q.size());
      return s;
   endfunction

   // Advance the model by one clock edge using the bus values presented at it
   task automatic model_step();
      bit          hit_w;
      int          off;
      int          pre;
      bit          popped;
      logic [15:0] nb;
      hit_w  = (bif.bus_addr[31:4] == BASE[31:4]) && (bif.bus_w != 4'b0000);
      off    = int'(bif.bus_addr[3:2]);
      pre    = q.size();
      popped = 1'b0;
      if (m_busy) begin
         m_elapsed++;
         if (m_elapsed == 10 * m_div) m_busy = 1'b0;
      end
      if (!m_busy && pre > 0) begin
         m_byte    = q.pop_front();
         m_div     = int'(m_baud);
         m_elapsed = 0;
         m_busy    = 1'b1;
         popped    = 1'b1;
      end
      if (hit_w) begin
         case (off)
            0: if (bif.bus_w[0]) begin
                  if (pre < DEPTH || popped) q.push_back(bif.bus_wdata[7:0]);
                  else m_ovf = 1'b1;
               end
            1: if (bif.bus_w[0] && bif.bus_wdata[3]) m_ovf = 1'b0;
            2: begin
                  nb = m_baud;
                  if (bif.bus_w[0]) nb[7:0]  = bif.bus_wdata[7:0];
                  if (bif.bus_w[1]) nb[15:8] = bif.bus_wdata[15:8];
                  if (nb == 16'd0) nb = 16'd1;
                  m_baud = nb;
               end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic bus_idle();
      bif.bus_r     = 1'b0;
      bif.bus_w     = 4'b0000;
      bif.bus_addr  = 32'h0;
      bif.bus_wdata = 32'h0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      bif.bus_r     = 1'b0;
      bif.bus_w     = be;
      bif.bus_addr  = addr;
      bif.bus_wdata = data;
      tick();
      bus_idle();
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
      bif.bus_r    = 1'b1;
      bif.bus_w    = 4'b0000;
      bif.bus_addr = addr;
      #1;
      data = bif.bus_rdata;
      hit  = bif.bus_hit;
      bif.bus_r    = 1'b0;
      bif.bus_addr = 32'h0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        h;
      bus_idle();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (txd !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_txd: got %b expected 1", txd);
      end
      bus_read(A_ST, d, h);
      vectors++;
      if (h !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_status_hit: got %b expected 1", h);
      end
      vectors++;
      if (d !== 32'h0000_0004 || d !== exp_status()) begin
         miscompares++;
         $display("[TB] FAIL reset_status: got %h expected %h", d, 32'h0000_0004);
      end
      bus_read(A_BD, d, h);
      vectors++;
      if (d !== 32'd434) begin
         miscompares++;
         $display("[TB] FAIL reset_bauddiv: got %0d expected 434", d);
      end
   endtask

   task automatic test_single_frame();
      logic [31:0] d;
      logic        h;
      int          busy_cycles;
      bus_write(A_BD, 32'd4, 4'b0011);
      bus_write(A_TX, 32'h0000_00A5, 4'b0001);
      busy_cycles = 0;
      for (int i = 0; i < 44; i++) begin
         tick();
         vectors++;
         if (txd !== exp_txd()) begin
            miscompares++;
            $display("[TB] FAIL frame_a5_txd[%0d]: got %b expected %b", i, txd, exp_txd());
         end
         bus_read(A_ST, d, h);
         vectors++;
         if (d[0] !== m_busy) begin
            miscompares++;
            $display("[TB] FAIL frame_a5_busy[%0d]: got %b expected %b", i, d[0], m_busy);
         end
         if (d[0] === 1'b1) busy_cycles++;
      end
      vectors++;
      if (busy_cycles !== 40) begin
         miscompares++;
         $display("[TB] FAIL frame_a5_length: got %0d expected 40", busy_cycles);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic        h;
      int          busy_cycles;
      busy_cycles = 0;
      bus_write(A_BD, 32'd2, 4'b0011);
      bus_write(A_TX, 32'h01, 4'b0001);
      bus_write(A_TX, 32'h02, 4'b0001);
      bus_read(A_ST, d, h);
      if (d[0] === 1'b1) busy_cycles++;
      bus_write(A_TX, 32'h03, 4'b0001);
      bus_read(A_ST, d, h);
      if (d[0] === 1'b1) busy_cycles++;
      vectors++;
      if (d[12:8] !== 5'd2 || d !== exp_status()) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: got %h expected %h", d, exp_status());
      end
      for (int i = 0; i < 60; i++) begin
         tick();
         vectors++;
         if (txd !== exp_txd()) begin
            miscompares++;
            $display("[TB] FAIL b2b_txd[%0d]: got %b expected %b", i, txd, exp_txd());
         end
         bus_read(A_ST, d, h);
         if (d[0] === 1'b1) busy_cycles++;
      end
      vectors++;
      if (busy_cycles !== 60) begin
         miscompares++;
         $display("[TB] FAIL b2b_gapless_length: got %0d expected 60", busy_cycles);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      logic        h;
      bus_write(A_BD, 32'd1000, 4'b0011);
      for (int i = 0; i < 18; i++) begin
         bus_write(A_TX, $urandom, 4'b0001);
      end
      bus_read(A_ST, d, h);
      vectors++;
      if (d[1] !== 1'b1 || d[3] !== 1'b1 || d[12:8] !== 5'd16 || d !== exp_status()) begin
         miscompares++;
         $display("[TB] FAIL overflow_status: got %h expected %h", d, exp_status());
      end
      bus_write(A_ST, 32'h0000_0008, 4'b0010);
      bus_read(A_ST, d, h);
      vectors++;
      if (d[3] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overflow_clear_wrong_lane: got %b expected 1", d[3]);
      end
      bus_write(A_ST, 32'h0000_0008, 4'b0001);
      bus_read(A_ST, d, h);
      vectors++;
      if (d[3] !== 1'b0 || d !== exp_status()) begin
         miscompares++;
         $display("[TB] FAIL overflow_clear: got %h expected %h", d, exp_status());
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      logic        h;
      logic [7:0]  b;
      bit          reached;
      rst_n = 1'b0;
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      @(negedge clk);
      b = 8'($urandom) & 8'hFD;
      bus_write(A_BD, 32'd8, 4'b0011);
      bus_write(A_TX, {24'h0, b}, 4'b0001);
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         tick();
         if (m_busy && m_elapsed == 19) reached = 1'b1;
      end
      vectors++;
      if (!reached) begin
         miscompares++;
         $display("[TB] FAIL areset_reach_data: got not-reached expected reached");
      end
      vectors++;
      if (txd !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL areset_pre_txd: got %b expected 0", txd);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (txd !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL areset_txd_async: got %b expected 1", txd);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus_read(A_ST, d, h);
      vectors++;
      if (d !== 32'h0000_0004) begin
         miscompares++;
         $display("[TB] FAIL areset_status: got %h expected 00000004", d);
      end
      bus_read(A_BD, d, h);
      vectors++;
      if (d !== 32'd434) begin
         miscompares++;
         $display("[TB] FAIL areset_bauddiv: got %0d expected 434", d);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      logic        h;
      bus_read(A_UNMAP, d, h);
      vectors++;
      if (h !== 1'b1 || d !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL unmapped12_read: got hit=%b data=%h expected hit=1 data=0", h, d);
      end
      bus_write(A_UNMAP, 32'hFFFF_FFFF, 4'b1111);
      bus_write(A_OUT, 32'h0000_0055, 4'b0011);
      bus_write(A_OUT + 32'd8, 32'h0000_0007, 4'b0011);
      bus_read(A_OUT, d, h);
      vectors++;
      if (h !== 1'b0 || d !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL outside_read: got hit=%b data=%h expected hit=0 data=0", h, d);
      end
      bif.bus_addr = A_ST;
      #1;
      vectors++;
      if (bif.bus_hit !== 1'b0 || bif.bus_rdata !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL no_strobe: got hit=%b data=%h expected hit=0 data=0", bif.bus_hit, bif.bus_rdata);
      end
      bus_idle();
      tick();
      vectors++;
      if (txd !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL unmapped_txd: got %b expected 1", txd);
      end
      bus_read(A_BD, d, h);
      vectors++;
      if (d !== {16'h0, m_baud} || d !== 32'd434) begin
         miscompares++;
         $display("[TB] FAIL unmapped_bauddiv: got %h expected %h", d, {16'h0, m_baud});
      end
      bus_read(A_ST, d, h);
      vectors++;
      if (d !== exp_status()) begin
         miscompares++;
         $display("[TB] FAIL unmapped_status: got %h expected %h", d, exp_status());
      end
   endtask

   task automatic test_baud_lanes();
      logic [31:0] d;
      logic        h;
      bus_write(A_BD, 32'h0, 4'b0011);
      bus_read(A_BD, d, h);
      vectors++;
      if (d !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL baud_zero: got %h expected 00000001", d);
      end
      bus_write(A_BD, 32'h0000_3700, 4'b0010);
      bus_read(A_BD, d, h);
      vectors++;
      if (d !== 32'h0000_3701) begin
         miscompares++;
         $display("[TB] FAIL baud_lane1: got %h expected 00003701", d);
      end
      bus_write(A_BD, 32'hABCD_0012, 4'b1101);
      bus_read(A_BD, d, h);
      vectors++;
      if (d !== 32'h0000_3712 || d !== {16'h0, m_baud}) begin
         miscompares++;
         $display("[TB] FAIL baud_lane0: got %h expected 00003712", d);
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic        h;
      int          r;
      bit          drained;
      bus_write(A_BD, 32'd1 + ($urandom % 3), 4'b0011);
      for (int i = 0; i < 700; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 45) begin
            bif.bus_addr = A_TX;
            bif.bus_w = 4'b0001 | (4'($urandom) & 4'b1110);
            bif.bus_wdata = $urandom;
         end else if (r < 50) begin
            bif.bus_addr = A_TX;
            bif.bus_w = 4'b1110;
            bif.bus_wdata = $urandom;
         end else if (r < 56) begin
            bif.bus_addr = A_BD;
            bif.bus_w = 4'b0011;
            bif.bus_wdata = $urandom_range(0, 3);
         end else if (r < 60) begin
            bif.bus_addr = A_ST;
            bif.bus_w = 4'b0001;
            bif.bus_wdata = 32'h8;
         end
         tick();
         bus_idle();
         vectors++;
         if (txd !== exp_txd()) begin
            miscompares++;
            $display("[TB] FAIL rand_txd[%0d]: got %b expected %b", i, txd, exp_txd());
         end
         if (i % 4 == 0) begin
            bus_read(A_ST, d, h);
            vectors++;
            if (d !== exp_status()) begin
               miscompares++;
               $display("[TB] FAIL rand_status[%0d]: got %h expected %h", i, d, exp_status());
            end
         end
      end
      drained = 1'b0;
      for (int i = 0; i < 3000 && !drained; i++) begin
         tick();
         vectors++;
         if (txd !== exp_txd()) begin
            miscompares++;
            $display("[TB] FAIL drain_txd[%0d]: got %b expected %b", i, txd, exp_txd());
         end
         if (!m_busy && q.size() == 0) drained = 1'b1;
      end
      vectors++;
      if (!drained) begin
         miscompares++;
         $display("[TB] FAIL drain_timeout: got busy expected idle");
      end
      bus_read(A_ST, d, h);
      vectors++;
      if (d !== exp_status() || d[2:0] !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL drain_status: got %h expected %h", d, exp_status());
      end
   endtask

   // Scenario sequence
   initial begin
      model_reset();
      bus_idle();
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_async_reset();
      test_unmapped();
      test_baud_lanes();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
